// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Reports unsigned borrow, signed overflow and zero once the last bit is processed.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             x_bit, y_bit, d_bit, borrow_nx;
  logic [WIDTH-1:0] res_next;

  assign x_bit     = sa_q[0];
  assign y_bit     = sb_q[0];
  assign d_bit     = x_bit ^ y_bit ^ br_q;
  assign borrow_nx = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  // New bit enters at the MSB; after WIDTH shifts bit 0 lands in position 0.
  assign res_next  = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = borrow_nx;
        res_d = res_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // br_q is the borrow into the MSB; borrow_nx is the borrow out of it.
          diff_d  = res_next;
          bout_d  = borrow_nx;
          ovf_d   = br_q ^ borrow_nx;
          zero_d  = (res_next == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=8 vectors, exhaustive WIDTH=2,
// random WIDTH=32 against an arithmetic reference.
module tb_serial_subtractor;

  localparam longint SMAX32 = 64'sd2147483647;
  localparam longint SMIN32 = -SMAX32 - 64'sd1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // WIDTH=8 instance
  logic       s8, bin8, busy8, done8, bo8, ov8, z8;
  logic [7:0] a8, b8, diff8;
  // WIDTH=2 instance
  logic       s2, bin2, busy2, done2, bo2, ov2, z2;
  logic [1:0] a2, b2, diff2;
  // WIDTH=32 instance
  logic        s32, bin32, busy32, done32, bo32, ov32, z32;
  logic [31:0] a32, b32, diff32;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bo8), .ovf(ov8), .zero(z8)
  );
  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bo2), .ovf(ov2), .zero(z2)
  );
  serial_subtractor #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .bin(bin32),
    .busy(busy32), .done(done32), .diff(diff32), .bout(bo32), .ovf(ov32), .zero(z32)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One WIDTH=8 operation: latency, results, busy/done exclusivity, outputs held during RUN.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic ebo, input logic eov, input logic ez);
    int lat;
    bit stable, overlap, ran;
    logic [7:0] held;
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    held = diff8;
    @(posedge clk);
    lat = -1; stable = 1'b1; overlap = 1'b0; ran = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ran = busy8;
        s8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bi;
      end
      if (busy8 && done8) overlap = 1'b1;
      if (done8) begin lat = i - 1; break; end
      if (diff8 !== held) stable = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " result"}, {53'd0, diff8, bo8, ov8, z8}, {53'd0, ed, ebo, eov, ez});
    check({tag, " busy/hold"}, {60'd0, ran, busy8, overlap, stable}, 64'b1001);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic bi);
    int lat, sres;
    logic [2:0] full;
    logic ov;
    full = {1'b0, a} - {1'b0, b} - 3'(bi);
    sres = int'($signed(a)) - int'($signed(b)) - int'(bi);
    ov   = (sres > 1) || (sres < -2);
    @(negedge clk);
    s2 = 1'b1; a2 = a; b2 = b; bin2 = bi;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) s2 = 1'b0;
      if (done2) begin lat = i - 1; break; end
    end
    check($sformatf("w2 %0d-%0d-%0d latency", a, b, bi), 64'(lat), 64'd2);
    check($sformatf("w2 %0d-%0d-%0d result", a, b, bi), {59'd0, diff2, bo2, ov2, z2},
          {59'd0, full[1:0], full[2], ov, full[1:0] == 2'd0});
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int lat;
    longint sres;
    logic [32:0] full;
    logic ov;
    full = {1'b0, a} - {1'b0, b} - 33'(bi);
    sres = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    ov   = (sres > SMAX32) || (sres < SMIN32);
    @(negedge clk);
    s32 = 1'b1; a32 = a; b32 = b; bin32 = bi;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) s32 = 1'b0;
      if (done32) begin lat = i - 1; break; end
    end
    check($sformatf("w32 %h-%h-%0d latency", a, b, bi), 64'(lat), 64'd32);
    check($sformatf("w32 %h-%h-%0d result", a, b, bi), {29'd0, diff32, bo32, ov32, z32},
          {29'd0, full[31:0], full[32], ov, full[31:0] == 32'd0});
  endtask

  initial begin
    int lat;
    bit saw_done;
    rst = 1'b1;
    s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    s2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    s32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset w8", {50'd0, busy8, done8, diff8, bo8, ov8, z8}, 64'd0);
    check("reset w32", {26'd0, busy32, done32, diff32, bo32, ov32, z32}, 64'd0);

    // directed WIDTH=8 vectors
    run8("05-03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    run8("03-05",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    run8("80-01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8("10-10",   8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    run8("00-00-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8("7F-FF",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    run8("00-80",   8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

    // start during RUN ignored; start held through done gives back-to-back
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) s8 = 1'b0;
      if (i == 3) begin s8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
      if (i == 4) begin a8 = 8'h20; b8 = 8'h01; end
      if (done8) begin lat = i - 1; break; end
    end
    check("ignore latency", 64'(lat), 64'd8);
    check("ignore result", {53'd0, diff8, bo8, ov8, z8}, {53'd0, 8'h02, 3'b000});
    @(posedge clk);
    @(negedge clk);
    check("b2b busy after done", {62'd0, busy8, done8}, 64'b10);
    s8 = 1'b0;
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin lat = i - 1; break; end
    end
    check("b2b latency", 64'(lat), 64'd8);
    check("b2b result", {53'd0, diff8, bo8, ov8, z8}, {53'd0, 8'h1F, 3'b000});

    // reset mid-RUN aborts with no done pulse
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) s8 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort outputs", {50'd0, busy8, done8, diff8, bo8, ov8, z8}, 64'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("abort no done", 64'(saw_done), 64'd0);
    run8("after rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // WIDTH=2 exhaustive
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          run2(2'(x), 2'(y), 1'(c));

    // WIDTH=32 boundaries then random
    run32(32'h0000_0000, 32'h0000_0001, 1'b0);
    run32(32'h8000_0000, 32'h0000_0001, 1'b0);
    run32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    for (int n = 0; n < 1000; n++)
      run32($urandom, $urandom, 1'($urandom_range(1, 0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
